// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : EX-stage unit: single-cycle AND/OR/ADD/SUB and an iterative
//               shift-add multiply that takes WIDTH steps.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUCTRL,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic             done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0]    c_OP_AND = 4'b0000;
    localparam logic [3:0]    c_OP_OR  = 4'b0001;
    localparam logic [3:0]    c_OP_ADD = 4'b0010;
    localparam logic [3:0]    c_OP_SUB = 4'b0110;
    localparam logic [3:0]    c_OP_MUL = 4'b0100;
    localparam logic [CW-1:0] c_LAST   = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_zero,   w_zero_nxt;
    logic             r_err,    w_err_nxt;
    logic             r_done,   w_done_nxt;
    logic [WIDTH-1:0] r_mcand,  w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
    logic [WIDTH-1:0] r_acc,    w_acc_nxt;
    logic [CW-1:0]    r_count,  w_count_nxt;

    logic [WIDTH-1:0] w_op_res;
    logic             w_legal;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_acc_step;

    always_comb begin
        w_op_res = '0;
        w_legal  = 1'b1;
        w_is_mul = 1'b0;
        case (ALUCTRL)
            c_OP_AND: w_op_res = a & b;
            c_OP_OR:  w_op_res = a | b;
            c_OP_ADD: w_op_res = a + b;
            c_OP_SUB: w_op_res = a - b;
            c_OP_MUL: w_is_mul = 1'b1;
            default:  w_legal  = 1'b0;
        endcase
    end

    // Accumulator value after the current step, including this step's partial product
    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_zero_nxt   = r_zero;
        w_err_nxt    = r_err;
        w_done_nxt   = 1'b0;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_count_nxt  = r_count;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    if (w_is_mul) begin
                        w_mcand_nxt  = a;
                        w_mplier_nxt = b;
                        w_acc_nxt    = '0;
                        w_count_nxt  = '0;
                        w_state_nxt  = S_MUL;
                    end else if (w_legal) begin
                        w_result_nxt = w_op_res;
                        w_zero_nxt   = (w_op_res == '0);
                        w_err_nxt    = 1'b0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_result_nxt = '0;
                        w_zero_nxt   = 1'b1;
                        w_err_nxt    = 1'b1;
                        w_done_nxt   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                // An abort wins over the final step; the architectural outputs keep their value
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt    = w_acc_step;
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_count_nxt  = r_count + CW'(1);
                    if (r_count == c_LAST) begin
                        w_result_nxt = w_acc_step;
                        w_zero_nxt   = (w_acc_step == '0);
                        w_err_nxt    = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_zero   <= w_zero_nxt;
            r_err    <= w_err_nxt;
            r_done   <= w_done_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_count  <= w_count_nxt;
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign err    = r_err;
    assign done   = r_done;
    assign busy   = (r_state == S_MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Scoreboard bench for alu_exec_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       ALUCTRL;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;
    logic             done;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit #(.WIDTH(WIDTH)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ALUCTRL(ALUCTRL),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .result (result),
        .zero   (zero),
        .err    (err),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done pulse is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got result=%0h zero=%0b err=%0b, no completion expected",
                         result, zero, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (result !== e.res || zero !== e.z || err !== e.e) begin
                    errors++;
                    $display("FAIL completion: got result=%0h zero=%0b err=%0b, expected result=%0h zero=%0b err=%0b",
                             result, zero, err, e.res, e.z, e.e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one single-cycle op; returns #1 after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] eres,
                         input logic ez, input logic ee);
        start   = 1'b1;
        ALUCTRL = op;
        a       = va;
        b       = vb;
        exp_q.push_back('{eres, ez, ee});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Multiply with optional ignored start (ign_at) or flush (fl_at) at a busy cycle index
    task automatic run_mul(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                           input logic [WIDTH-1:0] eres, input int ign_at,
                           input int fl_at, input logic [WIDTH-1:0] hold);
        int n;
        start   = 1'b1;
        ALUCTRL = 4'b0100;
        a       = va;
        b       = vb;
        if (fl_at == 0) exp_q.push_back('{eres, (eres == '0), 1'b0});
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == ign_at) begin
                start = 1'b1; ALUCTRL = 4'b0010; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            flush = (n == fl_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        flush = 1'b0;
        if (fl_at > 0) begin
            chk("flush_busy_cycles", n, fl_at);
            chk("flush_busy_low", busy, 1'b0);
            chk("flush_result_hold", result, hold);
            chk("flush_no_done", done, 1'b0);
        end else begin
            chk("mul_busy_cycles", n, WIDTH);
            chk("mul_done_at_end", done, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ALUCTRL = 4'b0; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, '0);
        chk("reset_zero", zero, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(4'b0010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0);
        chk("add_busy", busy, 1'b0);
        chk("add_done", done, 1'b1);

        issue(4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        issue(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("sub_b2b_done", done, 1'b1);

        run_mul(32'd6, 32'd7, 32'd42, 10, 0, '0);
        run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0, 0, '0);

        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0);

        run_mul(32'd3, 32'd5, '0, 0, 15, 32'h0000_FFF0);
        chk("flush_zero_hold", zero, 1'b0);
        chk("flush_err_hold", err, 1'b0);

        issue(4'b1111, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);
        issue(4'b1000, 32'd5, 32'd0, 32'd0, 1'b1, 1'b1);
        issue(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        // start with flush in IDLE must be dropped
        flush = 1'b1; start = 1'b1; ALUCTRL = 4'b0010; a = 32'd8; b = 32'd8;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("idle_flush_no_done", done, 1'b0);
        chk("idle_flush_result", result, 32'd5);

        // Asynchronous reset between edges during a multiply
        start = 1'b1; ALUCTRL = 4'b0100; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_result", result, '0);
        chk("async_rst_zero", zero, 1'b0);
        chk("async_rst_err", err, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 1'b0);
        issue(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        chk("post_rst_add_done", done, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
